// File: rtl/mem_bus_arbiter_if.sv
// Command/response burst port shared by both requesters and the memory side.
// The master modport drives commands and the slave modport answers them.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_W-1:0]     cmd_address;
  logic [DATA_W-1:0]     cmd_data;
  logic [DATA_W/8-1:0]   cmd_mask;
  logic [LEN_W-1:0]      cmd_length;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_error;

  modport master (
    output cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask, cmd_length,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask, cmd_length,
    output cmd_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing one burst memory bus between the
// I-cache refiller (m0) and the D-cache command port (m1).
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master mem,
  output logic              grant,
  output logic              busy,
  output logic              unexpected_rsp
);

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  state_t             r_state;
  logic               r_grant;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_wr;
  logic [LEN_W-1:0]   r_len;
  logic               r_unexp;

  logic               w_sel_valid;
  logic               w_sel_wr;
  logic [LEN_W-1:0]   w_sel_len;
  logic               w_in_cmd;
  logic               w_in_rsp;
  logic               w_accept;

  assign w_in_cmd    = (r_state == CMD);
  assign w_in_rsp    = (r_state == RSP);
  assign w_sel_valid = r_grant ? m1.cmd_valid  : m0.cmd_valid;
  assign w_sel_wr    = r_grant ? m1.cmd_wr     : m0.cmd_wr;
  assign w_sel_len   = r_grant ? m1.cmd_length : m0.cmd_length;
  assign w_accept    = w_in_cmd & w_sel_valid & mem.cmd_ready;

  assign mem.cmd_valid   = w_in_cmd & w_sel_valid;
  assign mem.cmd_wr      = w_sel_wr;
  assign mem.cmd_address = r_grant ? m1.cmd_address : m0.cmd_address;
  assign mem.cmd_data    = r_grant ? m1.cmd_data    : m0.cmd_data;
  assign mem.cmd_mask    = r_grant ? m1.cmd_mask    : m0.cmd_mask;
  assign mem.cmd_length  = w_sel_len;

  assign m0.cmd_ready = w_in_cmd & ~r_grant & mem.cmd_ready;
  assign m1.cmd_ready = w_in_cmd &  r_grant & mem.cmd_ready;

  // Response data fans out to both ports; only rsp_valid is steered.
  assign m0.rsp_valid = w_in_rsp & ~r_grant & mem.rsp_valid;
  assign m1.rsp_valid = w_in_rsp &  r_grant & mem.rsp_valid;
  assign m0.rsp_data  = mem.rsp_data;
  assign m1.rsp_data  = mem.rsp_data;
  assign m0.rsp_error = mem.rsp_error;
  assign m1.rsp_error = mem.rsp_error;

  assign grant          = r_grant;
  assign busy           = (r_state != IDLE);
  assign unexpected_rsp = r_unexp;

  // Burst type and length are latched on acceptance so the requester may
  // present its next command while the response phase is still running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= 1'b1;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_len   <= '0;
      r_unexp <= 1'b0;
    end else begin
      r_unexp <= mem.rsp_valid & ~w_in_rsp;
      case (r_state)
        IDLE: begin
          if (m0.cmd_valid && m1.cmd_valid) r_grant <= ~r_grant;
          else if (m0.cmd_valid)            r_grant <= 1'b0;
          else if (m1.cmd_valid)            r_grant <= 1'b1;
          if (m0.cmd_valid || m1.cmd_valid) r_state <= CMD;
        end
        CMD: begin
          if (w_accept) begin
            r_wr  <= w_sel_wr;
            r_len <= w_sel_len;
            if (!w_sel_wr || r_cnt == w_sel_len) begin
              r_state <= RSP;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + LEN_W'(1);
            end
          end else if (!w_sel_valid && r_cnt == '0) begin
            // Withdrawn request before any beat moved: release the bus.
            r_state <= IDLE;
          end
        end
        RSP: begin
          if (mem.rsp_valid) begin
            if (r_wr || r_cnt == r_len) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + LEN_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: reset, read burst,
// round-robin fairness, throttled write burst, stray responses, mid-burst reset.
module tb_mem_bus_arbiter;

  logic clk;
  logic resetn;
  logic grant;
  logic busy;
  logic unexpectedRsp;

  int testCount;
  int failCount;
  int beat;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(3)) m0If ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(3)) m1If ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(3)) memIf ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(3)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .m0             (m0If.slave),
    .m1             (m1If.slave),
    .mem            (memIf.master),
    .grant          (grant),
    .busy           (busy),
    .unexpected_rsp (unexpectedRsp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, input logic [2:0] len);
    if (port == 0) begin
      m0If.cmd_valid = valid; m0If.cmd_wr = wr; m0If.cmd_address = addr;
      m0If.cmd_data = data; m0If.cmd_mask = mask; m0If.cmd_length = len;
    end else begin
      m1If.cmd_valid = valid; m1If.cmd_wr = wr; m1If.cmd_address = addr;
      m1If.cmd_data = data; m1If.cmd_mask = mask; m1If.cmd_length = len;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    resetn = 1'b0;
    testCount = 0;
    failCount = 0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    memIf.cmd_ready = 1'b0;
    memIf.rsp_valid = 1'b0;
    memIf.rsp_data  = 32'h0;
    memIf.rsp_error = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_m0_ready", m0If.cmd_ready, 0);
    checkOutput("rst_m1_ready", m1If.cmd_ready, 0);
    checkOutput("rst_mem_valid", memIf.cmd_valid, 0);
    checkOutput("rst_m0_rsp", m0If.rsp_valid, 0);
    checkOutput("rst_m1_rsp", m1If.rsp_valid, 0);
    checkOutput("rst_grant", grant, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_unexp", unexpectedRsp, 0);
    @(negedge clk);
    resetn = 1'b1;

    // m0 read burst of 8 beats
    cyc();
    applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 3'd7);
    memIf.cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd_idle_mem_valid", memIf.cmd_valid, 0);
    checkOutput("rd_idle_m0_ready", m0If.cmd_ready, 0);
    checkOutput("rd_idle_busy", busy, 0);
    cyc();
    @(negedge clk);
    checkOutput("rd_cmd_grant", grant, 0);
    checkOutput("rd_cmd_busy", busy, 1);
    checkOutput("rd_cmd_mem_valid", memIf.cmd_valid, 1);
    checkOutput("rd_cmd_m0_ready", m0If.cmd_ready, 1);
    checkOutput("rd_cmd_m1_ready", m1If.cmd_ready, 0);
    checkOutput("rd_cmd_addr", memIf.cmd_address, 32'h1000);
    checkOutput("rd_cmd_len", memIf.cmd_length, 7);
    checkOutput("rd_cmd_wr", memIf.cmd_wr, 0);
    cyc();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    @(negedge clk);
    checkOutput("rd_rsp_mem_valid", memIf.cmd_valid, 0);
    checkOutput("rd_rsp_wait", m0If.rsp_valid, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      memIf.rsp_valid = 1'b1;
      memIf.rsp_data  = 32'hA0 + i;
      @(negedge clk);
      checkOutput("rd_beat_m0_valid", m0If.rsp_valid, 1);
      checkOutput("rd_beat_m1_valid", m1If.rsp_valid, 0);
      checkOutput("rd_beat_data", m0If.rsp_data, 32'hA0 + i);
      checkOutput("rd_beat_busy", busy, 1);
    end
    cyc();
    memIf.rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("rd_done_busy", busy, 0);
    checkOutput("rd_done_unexp", unexpectedRsp, 0);

    // Round robin with both requesting, starting from reset
    cyc();
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 3'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 3'd0);
    @(negedge clk);
    checkOutput("rr_reset_grant", grant, 1);
    cyc();
    @(negedge clk);
    checkOutput("rr1_grant", grant, 0);
    checkOutput("rr1_m0_ready", m0If.cmd_ready, 1);
    checkOutput("rr1_m1_ready", m1If.cmd_ready, 0);
    checkOutput("rr1_addr", memIf.cmd_address, 32'h2000);
    cyc();
    memIf.rsp_valid = 1'b1;
    memIf.rsp_data  = 32'h55;
    @(negedge clk);
    checkOutput("rr1_m0_rsp", m0If.rsp_valid, 1);
    checkOutput("rr1_m1_rsp", m1If.rsp_valid, 0);
    cyc();
    memIf.rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("rr_gap_busy", busy, 0);
    cyc();
    @(negedge clk);
    checkOutput("rr2_grant", grant, 1);
    checkOutput("rr2_m1_ready", m1If.cmd_ready, 1);
    checkOutput("rr2_m0_ready", m0If.cmd_ready, 0);
    checkOutput("rr2_addr", memIf.cmd_address, 32'h3000);
    cyc();
    memIf.rsp_valid = 1'b1;
    @(negedge clk);
    checkOutput("rr2_m1_rsp", m1If.rsp_valid, 1);
    checkOutput("rr2_m0_rsp", m0If.rsp_valid, 0);
    cyc();
    memIf.rsp_valid = 1'b0;
    cyc();
    @(negedge clk);
    checkOutput("rr3_grant", grant, 0);
    checkOutput("rr3_m0_ready", m0If.cmd_ready, 1);
    cyc();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    memIf.rsp_valid = 1'b1;
    cyc();
    memIf.rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("rr_done_busy", busy, 0);

    // m1 write burst of 4 beats with memory ready toggling 1010...
    memIf.cmd_ready = 1'b0;
    applyStimulus(1, 1'b1, 1'b1, 32'h4000, 32'hD0, 4'h3, 3'd3);
    cyc();
    beat = 0;
    for (int k = 0; k < 7; k++) begin
      memIf.cmd_ready = (k % 2 == 0);
      m1If.cmd_data = 32'hD0 + beat;
      @(negedge clk);
      checkOutput("wr_mem_valid", memIf.cmd_valid, 1);
      checkOutput("wr_m1_ready", m1If.cmd_ready, (k % 2 == 0));
      checkOutput("wr_m0_ready", m0If.cmd_ready, 0);
      checkOutput("wr_data", memIf.cmd_data, 32'hD0 + beat);
      checkOutput("wr_mask", memIf.cmd_mask, 4'h3);
      checkOutput("wr_flag", memIf.cmd_wr, 1);
      if (k % 2 == 0) beat++;
      cyc();
    end
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    memIf.cmd_ready = 1'b0;
    memIf.rsp_valid = 1'b1;
    memIf.rsp_error = 1'b1;
    @(negedge clk);
    checkOutput("wr_beats", beat, 4);
    checkOutput("wr_rsp_mem_valid", memIf.cmd_valid, 0);
    checkOutput("wr_rsp_m1", m1If.rsp_valid, 1);
    checkOutput("wr_rsp_err", m1If.rsp_error, 1);
    checkOutput("wr_rsp_m0", m0If.rsp_valid, 0);
    checkOutput("wr_rsp_m0_ready", m0If.cmd_ready, 0);
    cyc();
    memIf.rsp_valid = 1'b0;
    memIf.rsp_error = 1'b0;
    @(negedge clk);
    checkOutput("wr_done_busy", busy, 0);

    // Stray response while idle
    cyc();
    memIf.rsp_valid = 1'b1;
    @(negedge clk);
    checkOutput("stray_m0_rsp", m0If.rsp_valid, 0);
    checkOutput("stray_m1_rsp", m1If.rsp_valid, 0);
    checkOutput("stray_unexp_pre", unexpectedRsp, 0);
    cyc();
    memIf.rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("stray_unexp", unexpectedRsp, 1);
    cyc();
    @(negedge clk);
    checkOutput("stray_unexp_clr", unexpectedRsp, 0);

    // Async reset during the third beat of an 8-beat read
    applyStimulus(0, 1'b1, 1'b0, 32'h5000, 32'h0, 4'hF, 3'd7);
    memIf.cmd_ready = 1'b1;
    cyc();
    cyc();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      memIf.rsp_valid = 1'b1;
      memIf.rsp_data  = 32'hB0 + i;
      @(negedge clk);
      checkOutput("rst6_beat", m0If.rsp_valid, 1);
      cyc();
    end
    memIf.rsp_valid = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst6_busy", busy, 0);
    checkOutput("rst6_grant", grant, 1);
    checkOutput("rst6_m0_rsp", m0If.rsp_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    @(negedge clk);
    checkOutput("rst6_unexp", unexpectedRsp, 1);
    checkOutput("rst6_m0_rsp_after", m0If.rsp_valid, 0);
    checkOutput("rst6_busy_after", busy, 0);
    cyc();
    memIf.rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst6_unexp_last", unexpectedRsp, 1);
    cyc();
    @(negedge clk);
    checkOutput("rst6_unexp_clr", unexpectedRsp, 0);

    applyStimulus(0, 1'b1, 1'b0, 32'h6000, 32'h0, 4'hF, 3'd1);
    cyc();
    @(negedge clk);
    checkOutput("new_grant", grant, 0);
    checkOutput("new_addr", memIf.cmd_address, 32'h6000);
    checkOutput("new_m0_ready", m0If.cmd_ready, 1);
    cyc();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    memIf.rsp_valid = 1'b1;
    memIf.rsp_data  = 32'h11;
    @(negedge clk);
    checkOutput("new_beat0", m0If.rsp_valid, 1);
    checkOutput("new_data0", m0If.rsp_data, 32'h11);
    cyc();
    memIf.rsp_data = 32'h22;
    @(negedge clk);
    checkOutput("new_beat1", m0If.rsp_valid, 1);
    checkOutput("new_data1", m0If.rsp_data, 32'h22);
    checkOutput("new_busy1", busy, 1);
    cyc();
    memIf.rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("new_done_busy", busy, 0);
    checkOutput("new_done_unexp", unexpectedRsp, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
